// File: rtl/counter_bank_pkg.sv
// Shared encodings and the terminal-value helper for the counter_bank channels.
package counter_bank_pkg;

    localparam int CNT_MAX_W = 32;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        END_WRAP = 1'b0,
        END_SAT  = 1'b1
    } end_mode_e;

    // Counting down always terminates at 1; counting up terminates at the modulus.
    function automatic logic [CNT_MAX_W-1:0] terminal_val(
        input logic [CNT_MAX_W-1:0] rollover_val,
        input dir_e                 dir
    );
        return (dir == DIR_DOWN) ? CNT_MAX_W'(1) : rollover_val;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One modulo counter channel: count register, terminal flag, wrap pulse and sticky wrap bit.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    tick,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    saturate,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    wrap_sticky
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    flag_q, flag_d;
    logic                    pulse_q, pulse_d;
    logic                    sticky_q, sticky_d;

    dir_e                    dir;
    end_mode_e               mode;
    logic [NUM_CNT_BITS-1:0] term;
    logic                    free_run;
    logic                    step;
    logic                    wrap;

    always_comb begin
        dir      = dir_e'(count_down);
        mode     = end_mode_e'(saturate);
        term     = NUM_CNT_BITS'(terminal_val(CNT_MAX_W'(rollover_val), dir));
        free_run = (rollover_val == '0);
        step     = count_enable & tick;
        cnt_d    = cnt_q;
        wrap     = 1'b0;

        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (step) begin
            // A zero modulus runs over the full 2^N range and ignores saturate.
            if (free_run) begin
                if (dir == DIR_UP) begin
                    cnt_d = cnt_q + ONE;
                    wrap  = (cnt_q == '1);
                end else begin
                    cnt_d = cnt_q - ONE;
                    wrap  = (cnt_q == '0);
                end
            end else if (dir == DIR_UP) begin
                if (cnt_q != rollover_val) begin
                    cnt_d = cnt_q + ONE;
                end else if (mode == END_WRAP) begin
                    cnt_d = ONE;
                    wrap  = 1'b1;
                end
            end else begin
                if (cnt_q > ONE) begin
                    cnt_d = cnt_q - ONE;
                end else if (mode == END_WRAP) begin
                    cnt_d = rollover_val;
                    wrap  = 1'b1;
                end
            end
        end

        // The flag only re-evaluates when the count register is written.
        flag_d = flag_q;
        if (clear || load || step) begin
            flag_d = !free_run && (cnt_d == term);
        end

        pulse_d  = wrap;
        sticky_d = clear ? 1'b0 : (sticky_q | wrap);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    assign count_out     = cnt_q;
    assign rollover_flag = flag_q;
    assign wrap_pulse    = pulse_q;
    assign wrap_sticky   = sticky_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent modulo counters; define COUNTER_BANK_PRESCALE_EN to gate
// every channel's count step with a shared programmable prescaler tick.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int NUM_CNT_BITS  = 4
`ifdef COUNTER_BANK_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 8
`endif
) (
    input  logic                                clk,
    input  logic                                n_rst,
`ifdef COUNTER_BANK_PRESCALE_EN
    input  logic [PRESCALE_BITS-1:0]            prescale_val,
`endif
    input  logic [NUM_CH-1:0]                   clear,
    input  logic [NUM_CH-1:0]                   load,
    input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH-1:0]                   count_enable,
    input  logic [NUM_CH-1:0]                   count_down,
    input  logic [NUM_CH-1:0]                   saturate,
    input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]                   rollover_flag,
    output logic [NUM_CH-1:0]                   wrap_pulse,
    output logic [NUM_CH-1:0]                   wrap_sticky
);

    logic tick;

`ifdef COUNTER_BANK_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] pre_q, pre_d;

    // Returning on >= keeps the prescaler bounded if prescale_val is lowered mid-period.
    always_comb begin
        tick  = (pre_q == prescale_val);
        pre_d = (pre_q >= prescale_val) ? '0 : pre_q + PRESCALE_BITS'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_bank_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS)
        ) u_ch (
            .clk           (clk),
            .n_rst         (n_rst),
            .tick          (tick),
            .clear         (clear[i]),
            .load          (load[i]),
            .load_val      (load_val[i]),
            .count_enable  (count_enable[i]),
            .count_down    (count_down[i]),
            .saturate      (saturate[i]),
            .rollover_val  (rollover_val[i]),
            .count_out     (count_out[i]),
            .rollover_flag (rollover_flag[i]),
            .wrap_pulse    (wrap_pulse[i]),
            .wrap_sticky   (wrap_sticky[i])
        );
    end

endmodule
